instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Instruction fetch front end for the MIPS datapath. It produces the instruction word whose opcode field feeds the control/decode unit.
- Holds the fetch PC and issues word reads to a synchronous instruction ROM with 1-cycle read latency.
- Buffers returned words in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding the stale in-flight read.

Parameters:
RESET_PC, 32'h0040_0000, first fetch address after reset (text segment base).
ROM_ADDR_W, 6, instruction ROM word-address width (64 words).

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
rom_en_o  out  1  ROM read request this cycle
rom_addr_o  out  ROM_ADDR_W  word address = (fetch_pc - RESET_PC)[ROM_ADDR_W+1:2]
rom_data_i  in  32  ROM read data, valid in the cycle after rom_en_o
instr_valid_o  out  1  queue head holds a valid instruction
instr_ready_i  in  1  decode accepts head this cycle
instr_o  out  32  head instruction; 32'h0 when not valid
op_o  out  6  instr_o[31:26], drives control-unit OP input
pc_o  out  32  PC of head instruction
pc_plus4_o  out  32  pc_o + 4, modulo 2^32
redirect_i  in  1  branch/jump taken; flush and refetch
redirect_pc_i  in  32  new fetch target
misalign_o  out  1  one-cycle pulse when redirect_pc_i[1:0] != 0

Behaviour:
Reset values:
- rom_en_o=0, instr_valid_o=0, instr_o=0, op_o=0, pc_o=RESET_PC, misalign_o=0.
- fetch_pc=RESET_PC, queue empty, in-flight flag clear.

Internal state:
- fetch_pc, in-flight flag plus its PC, 2-entry FIFO of {instr, pc}, count 0..2.

Handshake and issue:
- pop = instr_valid_o & instr_ready_i.
- instr_valid_o = (count != 0); head outputs are stable while valid and not ready.
- rom_en_o = ~reset & ~redirect_i & (count + inflight - pop < 2). The ready->rom_en_o path is combinational, which allows full throughput.
- On issue: fetch_pc <= fetch_pc + 4 (32-bit wrap), inflight <= 1, inflight_pc <= fetch_pc.
- Cycle after issue: rom_data_i and inflight_pc are pushed to the FIFO tail (unless the read was killed). Push and pop in the same cycle leaves count unchanged.
- Latency: rom_en_o in cycle t gives instr_valid_o in cycle t+2 (FIFO head registered, no bypass).
- Steady state with instr_ready_i held 1: one instruction per cycle.

Redirect (cycle t):
- Has priority over issue and push. A pop in cycle t still counts as accepted.
- FIFO cleared at end of t; instr_valid_o=0 in t+1.
- A read issued in t-1 (data arriving in t) is discarded.
- fetch_pc <= {redirect_pc_i[31:2], 2'b00}; misalign_o=1 in t+1 if low bits were nonzero.
- First redirected request in t+1; its instruction is valid in t+3.
- Back-to-back redirects: the last one wins, and each restarts the t+3 timing.

Boundaries:
- Count never exceeds 2; the issue rule guarantees space for every in-flight return.
- fetch_pc outside the ROM window aliases via the truncated address; no error is raised.
- Reset asserted mid-operation: all state returns to reset values at that edge. A ROM response arriving during or right after reset is ignored. First post-reset request occurs in the first cycle with reset=0.

Test Plan:
1. Reset release, instr_ready_i=1, ROM[k]=k+1 -> rom_en_o=1 at cycle 0 with addr 0; instr_valid_o from cycle 2; instr_o=1,2,3,... on consecutive cycles; pc_o=0x00400000,0x00400004,...; pc_plus4_o=pc_o+4.
2. Ready low for 5 cycles after first valid -> head held at instr 1 / pc 0x00400000; count reaches 2; rom_en_o stays 0 until ready returns; on release, no instruction is lost or duplicated.
3. Redirect to 0x00400040 while 2 entries are queued and 1 read is in flight -> valid drops the next cycle; stale data is never output; next valid instr_o=ROM[16] with pc_o=0x00400040, 3 cycles after the redirect.
4. Redirect to 0x00400023 -> misalign_o pulses once; fetch resumes at 0x00400020.
5. Redirect on two consecutive cycles (0x00400010, then 0x00400080) -> only the ROM[32] stream appears, at pc 0x00400080.
6. Reset asserted for 1 cycle while valid=1 and a read is in flight -> outputs return to reset values; the stream restarts at RESET_PC with the cycle-2 latency.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction ROM read port, decode-side handshake and redirect.
// master is the fetch unit's view; slave is the ROM/decode/branch environment.
interface instruction_fetch_unit_if #(
    parameter int unsigned ROM_ADDR_W = 6
);
    logic                  rom_en_o;
    logic [ROM_ADDR_W-1:0] rom_addr_o;
    logic [31:0]           rom_data_i;
    logic                  instr_valid_o;
    logic                  instr_ready_i;
    logic [31:0]           instr_o;
    logic [5:0]            op_o;
    logic [31:0]           pc_o;
    logic [31:0]           pc_plus4_o;
    logic                  redirect_i;
    logic [31:0]           redirect_pc_i;
    logic                  misalign_o;

    modport master (
        output rom_en_o, rom_addr_o, instr_valid_o, instr_o, op_o,
               pc_o, pc_plus4_o, misalign_o,
        input  rom_data_i, instr_ready_i, redirect_i, redirect_pc_i
    );

    modport slave (
        input  rom_en_o, rom_addr_o, instr_valid_o, instr_o, op_o,
               pc_o, pc_plus4_o, misalign_o,
        output rom_data_i, instr_ready_i, redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch front end: issues ROM word reads, buffers returns in a 2-entry FIFO,
// and presents them to decode with valid/ready; redirects flush queue and in-flight read.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int unsigned ROM_ADDR_W = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);
    logic [31:0] r_fetch_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic [31:0] r_fifo_instr [2];
    logic [31:0] r_fifo_pc    [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic        r_misalign;

    logic        w_valid;
    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic        w_tail;
    logic [2:0]  w_occupancy;
    logic [31:0] w_head_instr;

    assign w_valid     = (r_count != 2'd0);
    assign w_pop       = w_valid & bus.instr_ready_i;
    assign w_occupancy = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    // Issue only when every outstanding read is guaranteed a free slot on return.
    assign w_issue     = ~reset & ~bus.redirect_i & (w_occupancy < 3'd2);
    assign w_push      = r_inflight & ~bus.redirect_i;
    assign w_tail      = r_head ^ r_count[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc      <= RESET_PC;
            r_inflight      <= 1'b0;
            r_inflight_pc   <= RESET_PC;
            r_fifo_instr[0] <= '0;
            r_fifo_instr[1] <= '0;
            r_fifo_pc[0]    <= RESET_PC;
            r_fifo_pc[1]    <= RESET_PC;
            r_head          <= 1'b0;
            r_count         <= 2'd0;
            r_misalign      <= 1'b0;
        end else begin
            r_misalign <= bus.redirect_i & (bus.redirect_pc_i[1:0] != 2'b00);
            if (bus.redirect_i) begin
                r_fetch_pc <= {bus.redirect_pc_i[31:2], 2'b00};
                r_inflight <= 1'b0;
                r_head     <= 1'b0;
                r_count    <= 2'd0;
            end else begin
                if (w_push) begin
                    r_fifo_instr[w_tail] <= bus.rom_data_i;
                    r_fifo_pc[w_tail]    <= r_inflight_pc;
                end
                if (w_pop) begin
                    r_head <= ~r_head;
                end
                r_count    <= r_count + {1'b0, w_push} - {1'b0, w_pop};
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_inflight_pc <= r_fetch_pc;
                    r_fetch_pc    <= r_fetch_pc + 32'd4;
                end
            end
        end
    end

    // fetch_pc and RESET_PC are word aligned, so the offset slice needs no borrow from bits [1:0].
    assign bus.rom_en_o   = w_issue;
    assign bus.rom_addr_o = r_fetch_pc[ROM_ADDR_W+1:2] - RESET_PC[ROM_ADDR_W+1:2];

    assign w_head_instr      = r_fifo_instr[r_head];
    assign bus.instr_valid_o = w_valid;
    assign bus.instr_o       = w_valid ? w_head_instr : '0;
    assign bus.op_o          = w_valid ? w_head_instr[31:26] : '0;
    assign bus.pc_o          = r_fifo_pc[r_head];
    assign bus.pc_plus4_o    = r_fifo_pc[r_head] + 32'd4;
    assign bus.misalign_o    = r_misalign;
endmodule
